// File: rtl/r4.sv
// R4: 4-bit, 4-word accumulator machine driven by front-panel buttons and a
// free-running 555 clock. Program counter addresses a small RAM; the
// accumulator loads from a source mux (data_in, RAM, Acc+RAM, Acc-RAM).
// Optional feature macro: R4_SUB_EN builds the subtractor for MUX_switch=11;
// without it, MUX_switch=11 selects Acc (load becomes a hold).
module r4 #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  timer555,
    input  logic                  rst_n,
    input  logic                  JMP,
    input  logic                  Z_JMP,
    input  logic                  PZ_JMP,
    output logic                  Z_flag,
    output logic                  PZ_flag,
    input  logic                  Output_button,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [1:0]            MUX_switch,
    input  logic                  Acc_button,
    output logic [DATA_WIDTH-1:0] Acc,
    output logic [ADDR_WIDTH-1:0] counter,
    input  logic                  RAM_button,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] RAM_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] counter_reg;
    logic [ADDR_WIDTH-1:0] counter_next;
    logic [DATA_WIDTH-1:0] acc_reg;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [DATA_WIDTH-1:0] out_next;
    logic [DATA_WIDTH-1:0] mux_val;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic [DEPTH-1:0]      word_we;

    // RAM must clear on reset, so it is a register array rather than block RAM.
    logic [DATA_WIDTH-1:0] ram_reg [0:DEPTH-1];

    // Flags derive from the accumulator as it stands before the next edge.
    assign Z_flag   = (acc_reg == '0);
    assign PZ_flag  = ~acc_reg[DATA_WIDTH-1];

    // Combinational read at the current program counter.
    assign ram_rd   = ram_reg[counter_reg];

    assign RAM_out  = ram_rd;
    assign Acc      = acc_reg;
    assign counter  = counter_reg;
    assign data_out = out_reg;

    // Per-word write enable decoded from the pre-edge address.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign word_we[gi] = RAM_button && (counter_reg == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Accumulator source mux; arithmetic wraps at the data width.
    always_comb begin
        mux_val = data_in;
        case (MUX_switch)
            2'b00:   mux_val = data_in;
            2'b01:   mux_val = ram_rd;
            2'b10:   mux_val = acc_reg + ram_rd;
            default: begin
`ifdef R4_SUB_EN
                mux_val = acc_reg - ram_rd;
`else
                mux_val = acc_reg;
`endif
            end
        endcase
    end

    // Next program counter: unconditional jump, then Z, then PZ, else increment.
    always_comb begin
        counter_next = counter_reg + ADDR_WIDTH'(1);
        if (JMP) begin
            counter_next = data_in[ADDR_WIDTH-1:0];
        end else if (Z_JMP && Z_flag) begin
            counter_next = data_in[ADDR_WIDTH-1:0];
        end else if (PZ_JMP && PZ_flag) begin
            counter_next = data_in[ADDR_WIDTH-1:0];
        end
    end

    // Accumulator and output register loads; both see the pre-edge Acc.
    always_comb begin
        acc_next = acc_reg;
        out_next = out_reg;
        if (Acc_button) begin
            acc_next = mux_val;
        end
        if (Output_button) begin
            out_next = acc_reg;
        end
    end

    // Datapath state registers.
    always_ff @(posedge timer555 or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg <= '0;
            acc_reg     <= '0;
            out_reg     <= '0;
        end else begin
            counter_reg <= counter_next;
            acc_reg     <= acc_next;
            out_reg     <= out_next;
        end
    end

    // RAM words: cleared on reset, written from data_in at the old address.
    always_ff @(posedge timer555 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    ram_reg[i] <= data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_r4.sv
// Directed testbench for r4: reset, free run, jumps, Acc loads, RAM/ALU, output latch.
module tb_r4;

    logic       timer555;
    logic       rst_n;
    logic       JMP, Z_JMP, PZ_JMP;
    logic       Z_flag, PZ_flag;
    logic       Output_button;
    logic [3:0] data_out;
    logic [1:0] MUX_switch;
    logic       Acc_button;
    logic [3:0] Acc;
    logic [1:0] counter;
    logic       RAM_button;
    logic [3:0] data_in;
    logic [3:0] RAM_out;

    int n_checks = 0;
    int n_fails  = 0;

    r4 dut (
        .timer555      (timer555),
        .rst_n         (rst_n),
        .JMP           (JMP),
        .Z_JMP         (Z_JMP),
        .PZ_JMP        (PZ_JMP),
        .Z_flag        (Z_flag),
        .PZ_flag       (PZ_flag),
        .Output_button (Output_button),
        .data_out      (data_out),
        .MUX_switch    (MUX_switch),
        .Acc_button    (Acc_button),
        .Acc           (Acc),
        .counter       (counter),
        .RAM_button    (RAM_button),
        .data_in       (data_in),
        .RAM_out       (RAM_out)
    );

    initial timer555 = 1'b0;
    always #5 timer555 = ~timer555;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge timer555);
        #1;
    endtask

    task automatic idle();
        JMP = 0; Z_JMP = 0; PZ_JMP = 0;
        Acc_button = 0; RAM_button = 0; Output_button = 0;
        MUX_switch = 2'b00;
    endtask

    initial begin
        rst_n = 0; data_in = 4'd0;
        idle();
        #3;
        check("rst_counter", counter, 2'd0);
        check("rst_acc", Acc, 4'd0);
        check("rst_out", data_out, 4'd0);
        check("rst_ram", RAM_out, 4'd0);
        check("rst_z", Z_flag, 1'b1);
        check("rst_pz", PZ_flag, 1'b1);
        step();
        step();
        check("rst_held", counter, 2'd0);
        rst_n = 1;

        // Free run
        step(); check("run1", counter, 2'd1);
        step(); check("run2", counter, 2'd2);
        step(); check("run3", counter, 2'd3);
        step(); check("run0", counter, 2'd0);
        step(); check("run1b", counter, 2'd1);

        // Unconditional jump
        data_in = 4'b0010; JMP = 1;
        step(); check("jmp", counter, 2'd2);
        JMP = 0;
        step(); check("jmp_next", counter, 2'd3);

        // Acc load from data_in
        data_in = 4'b0011; MUX_switch = 2'b00; Acc_button = 1;
        step(); check("acc_load", Acc, 4'd3);
        check("acc_cnt", counter, 2'd0);
        check("acc_z", Z_flag, 1'b0);
        check("acc_pz", PZ_flag, 1'b1);
        Acc_button = 0;
        step(); check("pre_zjmp", counter, 2'd1);

        // Z_JMP with Z false increments; PZ_JMP with PZ true jumps
        data_in = 4'b0001; Z_JMP = 1;
        step(); check("zjmp_not_taken", counter, 2'd2);
        Z_JMP = 0; PZ_JMP = 1;
        step(); check("pzjmp_taken", counter, 2'd1);
        check("acc_hold", Acc, 4'd3);
        PZ_JMP = 0;

        // Mid-run async reset
        rst_n = 0;
        #1;
        check("async_counter", counter, 2'd0);
        check("async_acc", Acc, 4'd0);
        #2;
        rst_n = 1;

        // RAM writes: 5 at addr 1, 12 at addr 2
        step(); check("ram_cnt1", counter, 2'd1);
        data_in = 4'd5; RAM_button = 1;
        step(); check("ram_cnt2", counter, 2'd2);
        check("ram_rd2_before", RAM_out, 4'd0);
        data_in = 4'b1100;
        step(); check("ram_rd3", RAM_out, 4'd0);
        RAM_button = 0;
        data_in = 4'd5; Acc_button = 1;
        step(); check("acc5", Acc, 4'd5);
        Acc_button = 0;
        step(); check("ram_rd1", RAM_out, 4'd5);
        step(); check("ram_rd2", RAM_out, 4'b1100);
        MUX_switch = 2'b10; Acc_button = 1;
        step(); check("add_wrap", Acc, 4'd1);
        check("add_cnt", counter, 2'd3);

        // Acc=2 at addr 1, then MUX=11
        MUX_switch = 2'b00; data_in = 4'd2;
        step(); check("acc2", Acc, 4'd2);
        Acc_button = 0;
        step(); check("sub_addr", RAM_out, 4'd5);
        MUX_switch = 2'b11; Acc_button = 1;
        step();
`ifdef R4_SUB_EN
        check("sub_acc", Acc, 4'b1101);
        check("sub_pz", PZ_flag, 1'b0);
        Acc_button = 0; MUX_switch = 2'b00;
        data_in = 4'b0000; PZ_JMP = 1;
        step(); check("pzjmp_not_taken", counter, 2'd3);
        PZ_JMP = 0;
`else
        check("mux11_hold", Acc, 4'd2);
        check("mux11_pz", PZ_flag, 1'b1);
        Acc_button = 0; MUX_switch = 2'b00;
        step(); check("mux11_cnt", counter, 2'd3);
`endif
        // Acc=0 -> Z=1, Z_JMP taken (counter 0 -> 1 rather than ... via target)
        data_in = 4'd0; Acc_button = 1;
        step(); check("acc0", Acc, 4'd0);
        check("z_set", Z_flag, 1'b1);
        Acc_button = 0;
        data_in = 4'd2; Z_JMP = 1;
        step(); check("zjmp_taken", counter, 2'd2);
        Z_JMP = 0;

        // Output latch
        data_in = 4'd9; Acc_button = 1;
        step(); check("acc9", Acc, 4'd9);
        Acc_button = 0; Output_button = 1;
        step(); check("out9", data_out, 4'd9);
        Output_button = 0; data_in = 4'd4; Acc_button = 1;
        step(); check("acc4", Acc, 4'd4);
        check("out_hold", data_out, 4'd9);
        data_in = 4'd6; Output_button = 1;
        step(); check("out_old_acc", data_out, 4'd4);
        check("acc6", Acc, 4'd6);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
